// File: rtl/aes_pkg.sv
// aes_pkg: AES constants, S-box and Rcon shared by forward and inverse key schedules
package aes_pkg;
    localparam int NB = 4;
    localparam int NK = 4;
    localparam int NR = 10;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p ^= b[i] ? x : 8'h00;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (b^254, so 0 maps to 0) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq = b;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < 10; i++)
            if (i < int'(r)) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        return (r != 4'd0 && r <= 4'd10) ? {rc, 24'h0} : 32'h0;
    endfunction
endpackage

// File: rtl/aes_sbox_word.sv
// aes_sbox_word: four parallel S-box lookups on a 32-bit word
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] in_w,
    output logic [31:0] out_w
);
    assign out_w = {sbox(in_w[31:24]), sbox(in_w[23:16]), sbox(in_w[15:8]), sbox(in_w[7:0])};
endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: regenerates AES-128 round keys backward from the last round key
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] last_key,
    input  logic         rk_ready,
    output logic [0:127] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);
    state_t       state_q, state_d;
    logic [0:127] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [31:0]  w0, w1, w2, w3, p3, sub;
    logic [0:127] prev_key;

    assign w0 = key_q[0:31];
    assign w1 = key_q[32:63];
    assign w2 = key_q[64:95];
    assign w3 = key_q[96:127];
    assign p3 = w3 ^ w2;

    // The previous key's last word is recovered first; it feeds RotWord/SubWord for word 0
    aes_sbox_word u_sbox (.in_w({p3[23:0], p3[31:24]}), .out_w(sub));

    assign prev_key = {w0 ^ sub ^ rcon(idx_q), w1 ^ w0, w2 ^ w1, p3};

    always_comb begin
        state_d = state_q;
        key_d = key_q;
        idx_d = idx_q;
        valid_d = valid_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                key_d = last_key;
                idx_d = 4'(NR);
                valid_d = 1'b1;
                busy_d = 1'b1;
                state_d = EMIT;
            end
        end else if (rk_ready) begin
            if (idx_q == 4'd0) begin
                valid_d = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b1;
                state_d = IDLE;
            end else begin
                key_d = prev_key;
                idx_d = idx_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q <= '0;
            idx_q <= '0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q <= key_d;
            idx_q <= idx_d;
            valid_q <= valid_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign round_key = key_q;
    assign round_idx = idx_q;
    assign rk_valid = valid_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Sequential inverse AES-128 key scheduler for the decryption datapath.
- Accepts the final round key (round Nr) and regenerates the round keys backward, Nr down to 0, one step per accepted output.
- Needs no stored full key table: it feeds the inverse cipher round by round and ends by recovering the original cipher key.
- Counterpart to the combinational forward key expansion used on the encryption side.

Parameters:
- Nk, 4, key length in 32-bit words; only 4 (AES-128) is supported.
- Nr, 10, number of rounds; first emitted round index = Nr.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on clk rising edge.
- start  in  1  load last_key and begin a sequence; honoured only when busy=0.
- last_key  in  [0:127]  round-Nr key; word0 = bits 0:31.
- rk_ready  in  1  consumer accepts round_key this cycle.
- round_key  out  [0:127]  current round key, registered.
- round_idx  out  [3:0]  round number of round_key.
- rk_valid  out  1  round_key/round_idx valid.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after round 0 is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge): round_key=0, round_idx=0, rk_valid=0, busy=0, done=0, FSM->IDLE. A reset mid-sequence aborts it with no further outputs.
- FSM states: IDLE, EMIT.
- IDLE, start=1 at a clock edge:
  - round_key<=last_key, round_idx<=Nr, rk_valid<=1, busy<=1, ->EMIT.
  - Latency start->first rk_valid = 1 cycle.
- EMIT, rk_valid=1, rk_ready=0: hold round_key, round_idx and rk_valid stable. No change is permitted while stalled.
- EMIT, handshake (rk_valid & rk_ready) with round_idx>0: round_key<=prev(round_key, round_idx), round_idx<=round_idx-1, rk_valid stays 1. This gives one key per cycle when rk_ready is held high; 11 keys in 11 cycles.
- EMIT, handshake with round_idx==0: rk_valid<=0, busy<=0, done<=1 for exactly one cycle, ->IDLE.
- start while busy=1: ignored and not queued. start in the same cycle as the final handshake is also ignored; the new start is taken the next cycle in IDLE.
- prev() for input words w0..w3 of round r (r in 1..Nr), all arithmetic bitwise XOR on 32-bit words:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(r)
  - RotWord rotates left by one byte: {b1,b2,b3,b0}.
  - Rcon(r) = {rc[r],24'h0}, with rc = 01,02,04,08,10,20,40,80,1b,36 for r=1..10; Rcon of any other r = 0.
  - The p0 path is 4 S-box lookups plus XORs, single-cycle combinational between registers.
- done never coincides with rk_valid=1.
- round_idx wraps never: the decrement is gated at 0.
- last_key is sampled only on the accepted start edge; later changes do not affect the running sequence.

Decomposition:
- Shared package aes_pkg holds:
  - constants Nb=4, Nk=4, Nr=10;
  - the S-box byte function (the same table as the forward expansion);
  - the Rcon function.
  Both the forward expansion and this block use the package.
- One sub-module, aes_sbox_word: 32-bit input, 32-bit output, four parallel S-box lookups. Instantiated once here.

Test Plan:
- FIPS-197 A.1: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start, rk_ready=1 -> rk_valid 1 cycle later with idx 10 and that key; next cycle idx 9 = ac7766f319fadc2128d12941575c006e; idx 0 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses the cycle after idx 0; 11 valid cycles total.
- Backpressure: same vector, rk_ready toggled pseudo-randomly -> identical 11-key sequence in order; round_key/round_idx stable on every stalled cycle; no key skipped or repeated.
- start while busy: pulse start with a different last_key at idx 6 -> ignored; sequence completes with the original keys; busy=0 only after the done cycle.
- Reset mid-run: rst_n=0 at idx 4 -> next cycle rk_valid=0, busy=0, round_key=0; a new start afterwards yields a full correct sequence from idx 10.
- Round-trip: 50 random cipher keys run through the forward expansion; the round-10 key is fed in -> every emitted key equals the forward expansion's round keys in reverse order.
- Back-to-back: start asserted on the first cycle of IDLE after done -> second sequence begins with 1-cycle latency and is correct.
